// File: rtl/seqdet_pkg.sv
// Shared types, sizing and pattern-step helpers for the time-multiplexed sequence detector.
// Pure declarations and combinational functions; no state.
// No flow control here; callers own the handshake.
package seqdet_pkg;

  localparam int N_CH    = 4;
  localparam int PAT_LEN = 4;
  localparam int CH_W    = $clog2(N_CH);
  localparam int PROG_W  = $clog2(PAT_LEN);

  typedef logic [CH_W-1:0]    ch_idx_t;
  typedef logic [PROG_W-1:0]  prog_t;
  typedef logic [PAT_LEN-1:0] pat_t;

  // First bit received is the MSB of the pattern.
  localparam pat_t DEF_PAT = pat_t'(4'b1010);

  // Pattern bit in arrival order: idx 0 is the first bit of the sequence.
  function automatic logic pat_bit(pat_t pat, int idx);
    pat_t sh;
    sh = pat >> (PAT_LEN - 1 - idx);
    return sh[0];
  endfunction

  // Mismatch fallback: the received string is the matched prefix pat[0..prog-1]
  // followed by b. Return the longest k <= prog whose last-k suffix equals the
  // first k pattern bits.
  function automatic prog_t next_prog(pat_t pat, prog_t prog, logic b);
    prog_t best;
    logic  ok;
    logic  sb;
    int    p;
    int    si;
    best = '0;
    p    = int'(prog);
    for (int k = 1; k < PAT_LEN; k++) begin
      if (k <= p) begin
        ok = 1'b1;
        for (int j = 0; j < PAT_LEN - 1; j++) begin
          if (j < k) begin
            si = p + 1 - k + j;
            sb = (si < p) ? pat_bit(pat, si) : b;
            if (sb != pat_bit(pat, j)) ok = 1'b0;
          end
        end
        if (ok) best = prog_t'(k);
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/seqdet_rr_arb.sv
// Round-robin arbiter: one-hot registered grant, rotating pointer, no back-to-back grant to one channel.
// Latency: request to grant >= 1 cycle, at most N cycles under full load.
// hold suppresses new grants and freezes the pointer; requesters simply wait.
module seqdet_rr_arb
  import seqdet_pkg::*;
#(
  parameter int N = N_CH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         hold,
  output logic [N-1:0] gnt
);

  localparam int W = $clog2(N);
  typedef logic [W-1:0] ptr_t;

  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] gnt_q, gnt_d;
  ptr_t         ptr_q, ptr_d;
  logic [N-1:0] elig;
  logic [N-1:0] sh;
  logic         found;
  int           idx;

  // Pick the first eligible requester at or after the pointer, wrapping.
  always_comb begin
    gnt_d = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    sh    = '0;
    // The channel holding the grant this cycle sits out the next one.
    elig  = req & ~gnt_q;
    if (!hold) begin
      for (int i = 0; i < N; i++) begin
        idx = (int'(ptr_q) + i) % N;
        sh  = elig >> idx;
        if (!found && sh[0]) begin
          found = 1'b1;
          gnt_d = ONE_HOT0 << idx;
          ptr_d = ptr_t'((idx + 1) % N);
        end
      end
    end
  end

  // Grant and pointer registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_q <= '0;
      ptr_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
    end
  end

  assign gnt = gnt_q;

endmodule

// File: rtl/seqdet_rr_sched.sv
// Shared Mealy pattern detector time-multiplexed over N_CH serial requesters (optional counters: SEQDET_CNT_EN).
// Latency: grant to det_valid 1 cycle; counter read 1 cycle.
// Requesters hold their bit until granted; the bit is consumed in the grant cycle.
module seqdet_rr_sched
  import seqdet_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH-1:0]    req,
  input  logic [N_CH-1:0]    data,
  output logic [N_CH-1:0]    gnt,
  input  logic               cfg_load,
  input  logic [PAT_LEN-1:0] cfg_pat,
  output logic               det_valid,
  output logic [CH_W-1:0]    det_ch,
  output logic               busy
`ifdef SEQDET_CNT_EN
  ,
  input  logic [CH_W-1:0]    cnt_sel,
  output logic [7:0]         cnt_rdata
`endif
);

  prog_t   prog_q [N_CH];
  prog_t   prog_d [N_CH];
  pat_t    pat_q, pat_d;
  logic    det_valid_q, det_valid_d;
  ch_idx_t det_ch_q, det_ch_d;
  logic    busy_q, busy_d;

  // cfg_load also freezes arbitration so the pointer is left untouched.
  seqdet_rr_arb #(.N(N_CH)) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .hold (cfg_load),
    .gnt  (gnt)
  );

  // Advance the granted channel's match progress and flag a full match.
  always_comb begin
    pat_d       = pat_q;
    det_valid_d = 1'b0;
    det_ch_d    = det_ch_q;
    busy_d      = 1'b0;
    for (int c = 0; c < N_CH; c++) prog_d[c] = prog_q[c];

    if (cfg_load) begin
      // New pattern invalidates all partial matches; any step this cycle is dropped.
      pat_d = cfg_pat;
      for (int c = 0; c < N_CH; c++) prog_d[c] = '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (gnt[c]) begin
          if (data[c] == pat_bit(pat_q, int'(prog_q[c]))) begin
            if (prog_q[c] == prog_t'(PAT_LEN - 1)) begin
              // Non-overlapping: a completed match restarts from scratch.
              prog_d[c]   = '0;
              det_valid_d = 1'b1;
              det_ch_d    = ch_idx_t'(c);
            end else begin
              prog_d[c] = prog_q[c] + 1'b1;
            end
          end else begin
            prog_d[c] = next_prog(pat_q, prog_q[c], data[c]);
          end
        end
      end
    end

    for (int c = 0; c < N_CH; c++) busy_d = busy_d | (prog_d[c] != '0);
  end

  // Detector state and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < N_CH; c++) prog_q[c] <= '0;
      pat_q       <= DEF_PAT;
      det_valid_q <= 1'b0;
      det_ch_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      for (int c = 0; c < N_CH; c++) prog_q[c] <= prog_d[c];
      pat_q       <= pat_d;
      det_valid_q <= det_valid_d;
      det_ch_q    <= det_ch_d;
      busy_q      <= busy_d;
    end
  end

  assign det_valid = det_valid_q;
  assign det_ch    = det_ch_q;
  assign busy      = busy_q;

`ifdef SEQDET_CNT_EN
  logic [7:0] cnt_q [N_CH];
  logic [7:0] cnt_d [N_CH];
  logic [7:0] cnt_rdata_q;

  // Saturating per-channel detection counters, cleared with the pattern.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      cnt_d[c] = cnt_q[c];
      if (cfg_load) begin
        cnt_d[c] = '0;
      end else if (det_valid_d && (det_ch_d == ch_idx_t'(c)) && (cnt_q[c] != 8'hFF)) begin
        cnt_d[c] = cnt_q[c] + 8'd1;
      end
    end
  end

  // Counter state and registered read port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < N_CH; c++) cnt_q[c] <= '0;
      cnt_rdata_q <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) cnt_q[c] <= cnt_d[c];
      cnt_rdata_q <= cnt_q[cnt_sel];
    end
  end

  assign cnt_rdata = cnt_rdata_q;
`endif

endmodule

// File: tb/tb_seqdet_rr_sched.sv
// Self-checking bench for seqdet_rr_sched: table vectors, directed corner sequences, random vs reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// The reference model tracks received-bit history per channel rather than a progress counter.
module tb_seqdet_rr_sched;
  import seqdet_pkg::*;

  localparam int N = N_CH;
  localparam int L = PAT_LEN;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    data;
  logic [N-1:0]    gnt;
  logic            cfg_load;
  logic [L-1:0]    cfg_pat;
  logic            det_valid;
  logic [CH_W-1:0] det_ch;
  logic            busy;
`ifdef SEQDET_CNT_EN
  logic [CH_W-1:0] cnt_sel;
  logic [7:0]      cnt_rdata;
`endif

  seqdet_rr_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .cfg_load  (cfg_load),
    .cfg_pat   (cfg_pat),
    .det_valid (det_valid),
    .det_ch    (det_ch),
    .busy      (busy)
`ifdef SEQDET_CNT_EN
    ,
    .cnt_sel   (cnt_sel),
    .cnt_rdata (cnt_rdata)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic int bitof(input logic [N-1:0] v, input int i);
    return int'(v >> i) & 1;
  endfunction

  // ---------------- reference model ----------------
  logic [N-1:0] m_gnt;
  int           m_ptr;
  int           m_pat;
  int           m_hist [N];
  int           m_hlen [N];
  int           m_dv;
  int           m_dch;
  int           m_busy;
  int           m_cnt  [N];
  int           m_rd;

  // Longest suffix of the history (since last clear) that is a proper pattern prefix.
  function automatic int m_prog(input int c);
    int best = 0;
    for (int k = 1; k < L; k++)
      if (k <= m_hlen[c] && ((m_hist[c] & ((1 << k) - 1)) == (m_pat >> (L - k)))) best = k;
    return best;
  endfunction

  task automatic model_step();
    int det = 0;
    int dc  = 0;
    int rd_next = 0;
    int found = 0;
    int j;
    logic [N-1:0] newg;
    if (!rst) begin
      m_gnt = '0; m_ptr = 0; m_pat = int'(DEF_PAT);
      for (int c = 0; c < N; c++) begin m_hist[c] = 0; m_hlen[c] = 0; m_cnt[c] = 0; end
      m_dv = 0; m_dch = 0; m_busy = 0; m_rd = 0;
      return;
    end
`ifdef SEQDET_CNT_EN
    rd_next = m_cnt[cnt_sel];
`endif
    if (cfg_load) begin
      m_pat = int'(cfg_pat);
      for (int c = 0; c < N; c++) begin m_hist[c] = 0; m_hlen[c] = 0; m_cnt[c] = 0; end
      m_gnt = '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        if (bitof(m_gnt, c) == 1) begin
          m_hist[c] = ((m_hist[c] << 1) | bitof(data, c)) & 16'hFFFF;
          if (m_hlen[c] < 16) m_hlen[c]++;
          if (m_hlen[c] >= L && (m_hist[c] & ((1 << L) - 1)) == m_pat) begin
            det = 1; dc = c; m_hist[c] = 0; m_hlen[c] = 0;
          end
        end
      end
      newg = '0;
      for (int i = 0; i < N; i++) begin
        j = (m_ptr + i) % N;
        if (found == 0 && bitof(req, j) == 1 && bitof(m_gnt, j) == 0) begin
          found = 1;
          newg = newg | (N'(1) << j);
          m_ptr = (j + 1) % N;
        end
      end
      m_gnt = newg;
      if (det == 1 && m_cnt[dc] < 255) m_cnt[dc]++;
    end
    m_dv = det;
    if (det == 1) m_dch = dc;
    m_busy = 0;
    for (int c = 0; c < N; c++) if (m_prog(c) != 0) m_busy = 1;
    m_rd = rd_next;
  endtask

  // One clock: advance the model with the current inputs, then compare everything.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("gnt", int'(gnt), int'(m_gnt));
    check("det_valid", int'(det_valid), m_dv);
    check("det_ch", int'(det_ch), m_dch);
    check("busy", int'(busy), m_busy);
`ifdef SEQDET_CNT_EN
    check("cnt_rdata", int'(cnt_rdata), m_rd);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // Offer one bit on channel c, wait (bounded) for its grant, then let it be consumed.
  task automatic send_bit(input ch_idx_t c, input logic b);
    int waited = 0;
    req[c]  = 1'b1;
    data[c] = b;
    while (gnt[c] !== 1'b1 && waited < 2 * N) begin
      tick();
      waited++;
    end
    check("send_bit_grant", int'(gnt[c]), 1);
    if (gnt[c] === 1'b1) tick();
    req[c] = 1'b0;
  endtask

  typedef struct {
    logic         rq;
    logic         dt;
    logic [N-1:0] g;
    logic         dv;
    logic         bz;
  } vec_t;

  vec_t tv [13];

  logic [3:0]   st [N];
  int           sidx [N];
  int           dcount [N];
  logic [N-1:0] gprev;
  logic [N-1:0] nreq;
  logic [N-1:0] ndat;
  logic [N-1:0] exp_g [5];

  initial begin
    // Pattern 1010 on ch0 alone: one grant every other cycle.
    tv[0]  = '{1'b1, 1'b1, 4'b0001, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b1};
    tv[2]  = '{1'b1, 1'b0, 4'b0001, 1'b0, 1'b1};
    tv[3]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
    tv[4]  = '{1'b1, 1'b1, 4'b0001, 1'b0, 1'b1};
    tv[5]  = '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b1};
    tv[6]  = '{1'b1, 1'b0, 4'b0001, 1'b0, 1'b1};
    tv[7]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 1'b0};
    tv[8]  = '{1'b1, 1'b1, 4'b0001, 1'b0, 1'b0};
    tv[9]  = '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b1};
    tv[10] = '{1'b1, 1'b0, 4'b0001, 1'b0, 1'b1};
    tv[11] = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
    tv[12] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b1};

    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;

    rst = 1'b0; req = '0; data = '0; cfg_load = 1'b0; cfg_pat = '0;
`ifdef SEQDET_CNT_EN
    cnt_sel = '0;
`endif

    // ---- reset state ----
    do_reset();
    check("rst0_gnt", int'(gnt), 0);
    check("rst0_det_valid", int'(det_valid), 0);
    check("rst0_det_ch", int'(det_ch), 0);
    check("rst0_busy", int'(busy), 0);

    // ---- table: 1,0,1,0,1,0 on ch0 ----
    for (int i = 0; i < 13; i++) begin
      req = '0; data = '0;
      req[0]  = tv[i].rq;
      data[0] = tv[i].dt;
      tick();
      check("tv_gnt", int'(gnt), int'(tv[i].g));
      check("tv_det_valid", int'(det_valid), int'(tv[i].dv));
      check("tv_det_ch", int'(det_ch), 0);
      check("tv_busy", int'(busy), int'(tv[i].bz));
    end
    req = '0; tick();

    // ---- fallback: 1,1,0,1,0 detects after the 5th bit ----
    do_reset();
    send_bit(0, 1'b1); send_bit(0, 1'b1);
    check("fb_busy_after_11", int'(busy), 1);
    send_bit(0, 1'b0); send_bit(0, 1'b1);
    check("fb_no_det_4th", int'(det_valid), 0);
    send_bit(0, 1'b0);
    check("fb_det_5th", int'(det_valid), 1);
    check("fb_det_ch", int'(det_ch), 0);

    // ---- all four channels requesting from reset ----
    do_reset();
    st[0] = 4'b1010; st[1] = 4'b0000; st[2] = 4'b1010; st[3] = 4'b0000;
    for (int c = 0; c < N; c++) begin sidx[c] = 0; dcount[c] = 0; end
    for (int cyc = 0; cyc < 20; cyc++) begin
      nreq = '0; ndat = '0;
      for (int c = 0; c < N; c++) begin
        if (sidx[c] < 4) begin
          nreq = nreq | (N'(1) << c);
          if (((st[c] >> (3 - sidx[c])) & 4'd1) == 4'd1) ndat = ndat | (N'(1) << c);
        end
      end
      req = nreq; data = ndat;
      gprev = gnt;
      tick();
      if (cyc < 5) check("rr_gnt_seq", int'(gnt), int'(exp_g[cyc]));
      for (int c = 0; c < N; c++) if (bitof(gprev, c) == 1) sidx[c]++;
      if (det_valid === 1'b1) dcount[int'(det_ch)]++;
    end
    req = '0;
    check("rr_det_ch0", dcount[0], 1);
    check("rr_det_ch1", dcount[1], 0);
    check("rr_det_ch2", dcount[2], 1);
    check("rr_det_ch3", dcount[3], 0);
    check("rr_busy_end", int'(busy), 0);

    // ---- cfg_load while ch0 is at prog 3 and granted ----
    do_reset();
    send_bit(0, 1'b1); send_bit(0, 1'b0); send_bit(0, 1'b1);
    check("cfg_busy_before", int'(busy), 1);
    req[0] = 1'b1; data[0] = 1'b0;
    for (int w = 0; w < 2 * N && gnt[0] !== 1'b1; w++) tick();
    check("cfg_granted", int'(gnt[0]), 1);
    cfg_load = 1'b1; cfg_pat = 4'b0110;
    tick();
    cfg_load = 1'b0; req[0] = 1'b0;
    check("cfg_no_det", int'(det_valid), 0);
    check("cfg_busy_clr", int'(busy), 0);
    send_bit(0, 1'b0); send_bit(0, 1'b1); send_bit(0, 1'b1);
    check("cfg_no_det_3", int'(det_valid), 0);
    send_bit(0, 1'b0);
    check("cfg_det_0110", int'(det_valid), 1);
    check("cfg_det_ch", int'(det_ch), 0);

    // ---- mid-stream reset ----
    send_bit(3, 1'b0); send_bit(3, 1'b1); send_bit(3, 1'b1); send_bit(3, 1'b0);
    check("pre_rst_det_ch3", int'(det_ch), 3);
    send_bit(2, 1'b1); send_bit(2, 1'b0);
    check("pre_rst_busy", int'(busy), 1);
    req = 4'b1100; data = '0; rst = 1'b0;
    tick();
    check("mid_rst_gnt", int'(gnt), 0);
    check("mid_rst_det_valid", int'(det_valid), 0);
    check("mid_rst_det_ch", int'(det_ch), 0);
    check("mid_rst_busy", int'(busy), 0);
    rst = 1'b1;
    tick();
    check("post_rst_first_gnt", int'(gnt), 4'b0100);
    req = '0; tick();
    send_bit(1, 1'b1); send_bit(1, 1'b0); send_bit(1, 1'b1); send_bit(1, 1'b0);
    check("post_rst_pat_1010", int'(det_valid), 1);
    check("post_rst_det_ch", int'(det_ch), 1);

`ifdef SEQDET_CNT_EN
    // ---- saturating counter on ch1 ----
    do_reset();
    for (int d = 0; d < 300; d++) begin
      send_bit(1, 1'b1); send_bit(1, 1'b0); send_bit(1, 1'b1); send_bit(1, 1'b0);
    end
    cnt_sel = 1; tick();
    check("cnt_ch1_sat", int'(cnt_rdata), 255);
    for (int c = 0; c < N; c++) begin
      if (c != 1) begin
        cnt_sel = CH_W'(c); tick();
        check("cnt_other_zero", int'(cnt_rdata), 0);
      end
    end
`endif

    // ---- random traffic against the model ----
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 299) != 0);
      cfg_load = ($urandom_range(0, 63) == 0);
      cfg_pat  = L'($urandom);
      req      = N'($urandom);
      data     = N'($urandom);
`ifdef SEQDET_CNT_EN
      cnt_sel  = CH_W'($urandom);
`endif
      tick();
    end
    rst = 1'b1; cfg_load = 1'b0; req = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
